ysyx_dispatch_queue: RTL and testbench

Parametrised multi-lane FIFO between IDU decode and RS/ROB allocation.
- Replaces the single-slot idu→exu pipe handoff with a WIDTH-wide, DEPTH-deep in-order queue.
- Accepts up to WIDTH decoded uops per cycle and releases up to WIDTH per cycle.
- Supports full-pipeline flush on branch mispredict, exception or fence_i.
- Payload is an opaque packed vector; it carries the flattened idu pipe fields.

---
 rtl/ysyx_dispatch_queue_pkg.sv | 37 +++
 rtl/ysyx_prefix_popcnt.sv | 24 ++
 rtl/ysyx_dispatch_queue.sv | 141 ++++++++++++++
 tb/tb_ysyx_dispatch_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_dispatch_queue_pkg.sv
// Shared types and size defaults for the IDU -> RS/ROB dispatch queue.
// YSYX_ISSUE_W and YSYX_DISPQ_SIZE may be overridden on the command line.
`ifndef YSYX_ISSUE_W
`define YSYX_ISSUE_W 2
`endif
`ifndef YSYX_DISPQ_SIZE
`define YSYX_DISPQ_SIZE 8
`endif

package ysyx_dispatch_queue_pkg;

    localparam int ISSUE_W    = `YSYX_ISSUE_W;
    localparam int DISPQ_SIZE = `YSYX_DISPQ_SIZE;

    // Queue pointer type for the default queue size
    typedef logic [$clog2(DISPQ_SIZE)-1:0] dispq_ptr_t;

    // Flattened idu pipe fields carried through the queue as an opaque payload
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  fu_type;
        logic [7:0]  fu_op;
        logic        rd_wen;
        logic        use_imm;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
    } idu_uop_t;

    localparam int UOP_W = $bits(idu_uop_t);

endpackage

// File: rtl/ysyx_prefix_popcnt.sv
// Counts the set lanes of a prefix mask and flags whether the mask is a
// legal contiguous prefix starting at lane 0.
module ysyx_prefix_popcnt #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]             i_mask,
    output logic [$clog2(WIDTH+1)-1:0]   o_cnt,
    output logic                         o_legal
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Sum the set lanes
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_cnt = o_cnt + CNT_W'(i_mask[i]);
        end
    end

    // A prefix mask plus one clears every set bit (all-ones wraps to zero)
    assign o_legal = ((i_mask & (i_mask + WIDTH'(1))) == '0);

endmodule

// File: rtl/ysyx_dispatch_queue.sv
// WIDTH-wide, DEPTH-deep in-order dispatch queue between IDU decode and
// RS/ROB allocation. Optional macro YSYX_DISPQ_BYPASS_EN lets an empty
// queue present incoming uops on the output in the same cycle.
module ysyx_dispatch_queue
    import ysyx_dispatch_queue_pkg::*;
#(
    parameter int WIDTH     = ISSUE_W,
    parameter int DEPTH     = DISPQ_SIZE,
    parameter int PAYLOAD_W = UOP_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in_valid,
    input  logic [WIDTH*PAYLOAD_W-1:0]   in_payload,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_valid,
    output logic [WIDTH*PAYLOAD_W-1:0]   out_payload,
    input  logic [WIDTH-1:0]             out_ready,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(WIDTH + 1);

    logic [PTR_W-1:0]           r_head;
    logic [PTR_W-1:0]           r_tail;
    logic [CNT_W-1:0]           r_count;
    logic [PAYLOAD_W-1:0]       r_mem [DEPTH];

    logic                       w_in_ready;
    logic [WIDTH-1:0]           w_out_valid;
    logic [WIDTH-1:0]           w_acc_mask;
    logic [PC_W-1:0]            w_in_cnt;
    logic [PC_W-1:0]            w_acc_cnt;
    logic                       w_in_legal;
    logic                       w_acc_legal;
    logic                       w_bypass;
    logic [CNT_W-1:0]           w_push_n;
    logic [CNT_W-1:0]           w_pop_n;
    logic [CNT_W-1:0]           w_skip_n;
    logic [CNT_W-1:0]           w_store_n;
    logic [CNT_W-1:0]           w_release_n;
    logic [WIDTH*PAYLOAD_W-1:0] w_wr_data;

    // Room for a whole group is decided from registered occupancy only
    assign w_in_ready = !reset && !flush
                        && ((CNT_W'(DEPTH) - r_count) >= CNT_W'(WIDTH));

`ifdef YSYX_DISPQ_BYPASS_EN
    assign w_bypass = (r_count == '0) && !reset && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Lane i shows the (i+1)-th oldest entry, or incoming lanes when bypassing
    always_comb begin
        w_out_valid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_out_valid[i] = !reset && !flush && (r_count > CNT_W'(i));
        end
`ifdef YSYX_DISPQ_BYPASS_EN
        if (w_bypass) begin
            w_out_valid = in_valid;
        end
`endif
    end

    // Read the oldest WIDTH entries starting at head, wrapping naturally
    always_comb begin
        out_payload = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_payload[i*PAYLOAD_W +: PAYLOAD_W] = r_mem[r_head + PTR_W'(i)];
        end
`ifdef YSYX_DISPQ_BYPASS_EN
        if (w_bypass) begin
            out_payload = in_payload;
        end
`endif
    end

    assign w_acc_mask = w_out_valid & out_ready;

    ysyx_prefix_popcnt #(.WIDTH(WIDTH)) u_push_cnt (
        .i_mask  (in_valid),
        .o_cnt   (w_in_cnt),
        .o_legal (w_in_legal)
    );

    ysyx_prefix_popcnt #(.WIDTH(WIDTH)) u_pop_cnt (
        .i_mask  (w_acc_mask),
        .o_cnt   (w_acc_cnt),
        .o_legal (w_acc_legal)
    );

    // Lanes consumed straight from the input are skipped when writing storage,
    // and then nothing leaves storage itself that cycle
    assign w_push_n    = w_in_ready ? CNT_W'(w_in_cnt) : '0;
    assign w_pop_n     = CNT_W'(w_acc_cnt);
    assign w_skip_n    = w_bypass ? w_pop_n : '0;
    assign w_store_n   = w_push_n - w_skip_n;
    assign w_release_n = w_bypass ? '0 : w_pop_n;
    assign w_wr_data   = in_payload >> (w_skip_n * PAYLOAD_W);

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;

    // Pointer and occupancy update; flush empties the queue like reset
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_release_n);
            r_tail  <= r_tail + PTR_W'(w_store_n);
            r_count <= r_count + w_store_n - w_release_n;
        end
    end

    // Storage write of the accepted lanes at tail onward; data is never reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(i) < w_store_n) begin
                r_mem[r_tail + PTR_W'(i)] <= w_wr_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Flag handshake misuse by either neighbour
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (w_in_legal);
            assert (w_acc_legal);
            assert (flush || w_in_ready || (in_valid == '0));
        end
    end

endmodule

// File: tb/tb_ysyx_dispatch_queue.sv
// Scoreboard bench for ysyx_dispatch_queue (WIDTH=2, DEPTH=8).
module tb_ysyx_dispatch_queue;

    localparam int W  = 2;
    localparam int D  = 8;
    localparam int PW = 192;
`ifdef YSYX_DISPQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              flush;
    logic [W-1:0]      in_valid;
    logic [W*PW-1:0]   in_payload;
    logic              in_ready;
    logic [W-1:0]      out_valid;
    logic [W*PW-1:0]   out_payload;
    logic [W-1:0]      out_ready;
    logic [3:0]        count;

    ysyx_dispatch_queue #(.WIDTH(W), .DEPTH(D), .PAYLOAD_W(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_payload (out_payload),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit           chk_cnt;
        int           cnt;
        bit           rdy;
        logic [W-1:0] vmask;
    } st_t;

    logic [PW-1:0] sb_q [$];   // uops accepted into the queue, oldest first
    st_t           st_q [$];   // expected status per cycle
    int            n_cmp = 0;
    int            n_err = 0;
    int            serial = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkp();
        serial++;
        return {$urandom, $urandom, $urandom, $urandom, $urandom, 32'(serial)};
    endfunction

    // One stimulus cycle: drive inputs at the falling edge and record what the
    // queue contract says the DUT must show this cycle.
    task automatic step(input logic [W-1:0] im, input logic [W-1:0] om,
                        input bit fl, input bit rs);
        int  cnt;
        int  nin;
        int  vis;
        bit  rdy;
        bit  byp;
        st_t rec;
        @(negedge clock);
        cnt = sb_q.size();
        rdy = !rs && !fl && (D - cnt >= W);
        if (!rdy && !fl) im = '0;
        nin = 0;
        for (int j = 0; j < W; j++) begin
            if (im[j] && nin == j) nin++;
        end
        for (int j = 0; j < W; j++) in_payload[j*PW +: PW] = mkp();
        byp = BYP && !rs && !fl && (cnt == 0);
        if (rs || fl)  vis = 0;
        else if (byp)  vis = nin;
        else           vis = (cnt < W) ? cnt : W;
        reset     = rs;
        flush     = fl;
        in_valid  = im;
        out_ready = om;
        rec.chk_cnt = !rs;
        rec.cnt     = cnt;
        rec.rdy     = rdy;
        rec.vmask   = W'((1 << vis) - 1);
        st_q.push_back(rec);
        if (rs || fl) sb_q.delete();
        else if (rdy) for (int j = 0; j < nin; j++) sb_q.push_back(in_payload[j*PW +: PW]);
    endtask

    // Monitor: compare status and pop the scoreboard on every output handshake
    initial begin
        st_t           rec;
        logic [PW-1:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (st_q.size() != 0) begin
                rec = st_q.pop_front();
                if (rec.chk_cnt) chk("count", 64'(count), 64'(rec.cnt));
                chk("in_ready", 64'(in_ready), 64'(rec.rdy));
                chk("out_valid", 64'(out_valid), 64'(rec.vmask));
                for (int i = 0; i < W; i++) begin
                    if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL pop_empty: lane %0d handshake with nothing expected", i);
                        end else begin
                            e = sb_q.pop_front();
                            n_cmp++;
                            if (out_payload[i*PW +: PW] !== e) begin
                                n_err++;
                                $display("FAIL payload lane%0d: actual %0h required %0h",
                                         i, out_payload[i*PW +: PW], e);
                            end
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed boundary sequences then randomized traffic
    initial begin
        logic [W-1:0] pre [3];
        pre[0] = 2'b00; pre[1] = 2'b01; pre[2] = 2'b11;
        reset = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0; in_payload = '0;
        step(2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 0, 0);               // idle after reset
        repeat (3) step(2'b11, 2'b00, 0, 0);    // fill to 6
        step(2'b11, 2'b00, 0, 0);               // 6 -> 8
        step(2'b11, 2'b00, 0, 0);               // full: not ready
        step(2'b00, 2'b11, 0, 0);               // 8 -> 6
        step(2'b00, 2'b11, 0, 0);               // 6 -> 4
        repeat (10) step(2'b11, 2'b11, 0, 0);   // steady state across wrap
        step(2'b00, 2'b01, 0, 0);               // 4 -> 3
        step(2'b01, 2'b01, 0, 0);               // partial push+pop holds 3
        step(2'b00, 2'b00, 0, 0);
        step(2'b11, 2'b00, 0, 0);               // 3 -> 5
        step(2'b11, 2'b11, 1, 0);               // flush with traffic
        step(2'b00, 2'b00, 0, 0);               // empty afterwards
        step(2'b11, 2'b01, 0, 0);               // push into empty, partial drain
        step(2'b00, 2'b01, 0, 0);
        for (int k = 0; k < 400; k++) begin
            step(pre[$urandom_range(0, 2)], pre[$urandom_range(0, 2)],
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
        end
        step(2'b11, 2'b00, 0, 0);
        step(2'b11, 2'b11, 0, 1);               // reset mid-burst
        step(2'b00, 2'b00, 0, 0);
        repeat (6) step(2'b00, 2'b11, 0, 0);
        @(negedge clock);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
